// File: rtl/accum_window.sv
// Windowed up/down accumulator. It sums WIN_LEN accepted samples and then presents the total
// with a one-cycle strobe and overflow/underflow status. Arithmetic is either wrap-around or saturating.
module accum_window #(
  parameter int DATA_W   = 4,
  parameter int ACC_W    = 8,
  parameter int WIN_LEN  = 4,
  parameter int SATURATE = 0,
  localparam int CNT_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sub,
  input  logic              sync_clr,
  output logic [ACC_W-1:0]  acc,
  output logic [CNT_W-1:0]  win_cnt,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  output logic              sum_ovf,
  output logic              sum_unf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);

  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_w_reg, ovf_w_next;
  logic             unf_w_reg, unf_w_next;
  logic [ACC_W-1:0] sum_reg, sum_next;
  logic             sum_valid_reg, sum_valid_next;
  logic             sum_ovf_reg, sum_ovf_next;
  logic             sum_unf_reg, sum_unf_next;

  logic [ACC_W:0]   d_ext;
  logic [ACC_W:0]   raw;
  logic             ovf_ev, unf_ev;
  logic [ACC_W-1:0] result;

  // Bit ACC_W of the widened sum is the carry on add and the borrow on subtract.
  always_comb begin
    d_ext  = {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
    raw    = in_sub ? ({1'b0, acc_reg} - d_ext) : ({1'b0, acc_reg} + d_ext);
    ovf_ev = ~in_sub & raw[ACC_W];
    unf_ev = in_sub & raw[ACC_W];
    result = raw[ACC_W-1:0];
    if (SATURATE != 0) begin
      if (ovf_ev)      result = {ACC_W{1'b1}};
      else if (unf_ev) result = '0;
    end
  end

  always_comb begin
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    ovf_w_next     = ovf_w_reg;
    unf_w_next     = unf_w_reg;
    sum_next       = sum_reg;
    sum_valid_next = 1'b0;
    sum_ovf_next   = sum_ovf_reg;
    sum_unf_next   = sum_unf_reg;
    if (sync_clr) begin
      acc_next   = '0;
      cnt_next   = '0;
      ovf_w_next = 1'b0;
      unf_w_next = 1'b0;
    end else if (in_valid) begin
      if (cnt_reg == LAST_CNT) begin
        sum_next       = result;
        sum_ovf_next   = ovf_w_reg | ovf_ev;
        sum_unf_next   = unf_w_reg | unf_ev;
        sum_valid_next = 1'b1;
        acc_next       = '0;
        cnt_next       = '0;
        ovf_w_next     = 1'b0;
        unf_w_next     = 1'b0;
      end else begin
        acc_next   = result;
        cnt_next   = cnt_reg + CNT_W'(1);
        ovf_w_next = ovf_w_reg | ovf_ev;
        unf_w_next = unf_w_reg | unf_ev;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_w_reg     <= 1'b0;
      unf_w_reg     <= 1'b0;
      sum_reg       <= '0;
      sum_valid_reg <= 1'b0;
      sum_ovf_reg   <= 1'b0;
      sum_unf_reg   <= 1'b0;
    end else begin
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      ovf_w_reg     <= ovf_w_next;
      unf_w_reg     <= unf_w_next;
      sum_reg       <= sum_next;
      sum_valid_reg <= sum_valid_next;
      sum_ovf_reg   <= sum_ovf_next;
      sum_unf_reg   <= sum_unf_next;
    end
  end

  assign acc       = acc_reg;
  assign win_cnt   = cnt_reg;
  assign sum_out   = sum_reg;
  assign sum_valid = sum_valid_reg;
  assign sum_ovf   = sum_ovf_reg;
  assign sum_unf   = sum_unf_reg;

endmodule

// File: tb/tb_accum_window.sv
// Directed bench for accum_window. It uses three instances: the default wrap configuration,
// a 5-bit saturating configuration, and a single-sample window configuration.
module tb_accum_window;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_sub = 1'b0;
  logic       sync_clr = 1'b0;

  logic [7:0] a_acc, a_sum;
  logic [1:0] a_cnt;
  logic       a_sv, a_ovf, a_unf;
  logic [4:0] s_acc, s_sum;
  logic [1:0] s_cnt;
  logic       s_sv, s_ovf, s_unf;
  logic [7:0] w_acc, w_sum;
  logic [0:0] w_cnt;
  logic       w_sv, w_ovf, w_unf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accum_window #(.DATA_W(4), .ACC_W(8), .WIN_LEN(4), .SATURATE(0)) u_a (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_data(in_data), .in_sub(in_sub),
    .sync_clr(sync_clr), .acc(a_acc), .win_cnt(a_cnt), .sum_out(a_sum), .sum_valid(a_sv),
    .sum_ovf(a_ovf), .sum_unf(a_unf));

  accum_window #(.DATA_W(4), .ACC_W(5), .WIN_LEN(4), .SATURATE(1)) u_s (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_data(in_data), .in_sub(in_sub),
    .sync_clr(sync_clr), .acc(s_acc), .win_cnt(s_cnt), .sum_out(s_sum), .sum_valid(s_sv),
    .sum_ovf(s_ovf), .sum_unf(s_unf));

  accum_window #(.DATA_W(4), .ACC_W(8), .WIN_LEN(1), .SATURATE(0)) u_w (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_data(in_data), .in_sub(in_sub),
    .sync_clr(sync_clr), .acc(w_acc), .win_cnt(w_cnt), .sum_out(w_sum), .sum_valid(w_sv),
    .sum_ovf(w_ovf), .sum_unf(w_unf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("%s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic v, input logic sub, input logic [3:0] d, input logic sc);
    @(negedge clk);
    in_valid = v;
    in_sub   = sub;
    in_data  = d;
    sync_clr = sc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0;
    sync_clr = 1'b0;
    clear = 1'b1;
    #2;
    clear = 1'b0;
  endtask

  initial begin
    clear = 1'b1;
    #1;
    chk("rst_acc", a_acc, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_sum", a_sum, 0);
    chk("rst_sv", a_sv, 0);
    chk("rst_flags", {a_ovf, a_unf}, 0);
    #10;
    clear = 1'b0;

    // add 1,2,3,4
    step(1, 0, 1, 0); chk("t1_acc1", a_acc, 1);
    step(1, 0, 2, 0); chk("t1_acc2", a_acc, 3);
    step(1, 0, 3, 0); chk("t1_acc3", a_acc, 6); chk("t1_sv_early", a_sv, 0);
    step(1, 0, 4, 0); chk("t1_acc4", a_acc, 0);
    chk("t1_sum", a_sum, 10); chk("t1_sv", a_sv, 1);
    chk("t1_ovf", a_ovf, 0); chk("t1_unf", a_unf, 0); chk("t1_cnt", a_cnt, 0);
    step(0, 0, 0, 0); chk("t1_sv_drop", a_sv, 0); chk("t1_sum_hold", a_sum, 10);

    // sub 5, add 3,3,3 (wrap)
    step(1, 1, 5, 0); chk("t2_acc1", a_acc, 251); chk("t2_cnt1", a_cnt, 1);
    step(1, 0, 3, 0); chk("t2_acc2", a_acc, 254);
    step(1, 0, 3, 0); chk("t2_acc3", a_acc, 1);
    step(1, 0, 3, 0);
    chk("t2_sum", a_sum, 4); chk("t2_unf", a_unf, 1); chk("t2_ovf", a_ovf, 1); chk("t2_sv", a_sv, 1);
    step(0, 0, 0, 0);

    // saturating instance: add 15,15,15, sub 1
    do_clear();
    step(1, 0, 15, 0); chk("t3_acc1", s_acc, 15);
    step(1, 0, 15, 0); chk("t3_acc2", s_acc, 30);
    step(1, 0, 15, 0); chk("t3_acc3", s_acc, 31);
    step(1, 1, 1, 0);
    chk("t3_sum", s_sum, 30); chk("t3_ovf", s_ovf, 1); chk("t3_unf", s_unf, 0); chk("t3_sv", s_sv, 1);
    step(1, 1, 7, 0); chk("t3_acc_clamp0", s_acc, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t3_sum2", s_sum, 0); chk("t3_unf2", s_unf, 1); chk("t3_ovf2", s_ovf, 0); chk("t3_sv2", s_sv, 1);
    step(0, 0, 0, 0);

    // asynchronous clear mid-window
    do_clear();
    step(1, 0, 3, 0);
    step(1, 0, 5, 0); chk("t4_acc_pre", a_acc, 8);
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    #1;
    chk("t4_acc_async", a_acc, 0); chk("t4_cnt_async", a_cnt, 0); chk("t4_sv_async", a_sv, 0);
    #1;
    clear = 1'b0;
    @(posedge clk); #1;
    chk("t4_sv_after", a_sv, 0);
    step(1, 0, 2, 0);
    step(1, 0, 2, 0);
    step(1, 0, 2, 0); chk("t4_acc3", a_acc, 6);
    step(1, 0, 2, 0); chk("t4_sum", a_sum, 8); chk("t4_sv", a_sv, 1);

    // sync_clr overrides a sample
    step(1, 0, 1, 0);
    step(1, 0, 1, 0); chk("t5_acc_pre", a_acc, 2);
    step(1, 0, 9, 1);
    chk("t5_acc", a_acc, 0); chk("t5_cnt", a_cnt, 0); chk("t5_sum_hold", a_sum, 8); chk("t5_sv", a_sv, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0); chk("t5_sv_early", a_sv, 0);
    step(1, 0, 1, 0); chk("t5_sum", a_sum, 4); chk("t5_sv2", a_sv, 1);

    // gapped in_valid pattern 1,0,0,1,0,1,1
    do_clear();
    step(1, 0, 1, 0); chk("t6_sv_a", a_sv, 0);
    step(0, 0, 1, 0); chk("t6_cnt_gap", a_cnt, 1);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0); chk("t6_cnt2", a_cnt, 2);
    step(0, 0, 1, 0); chk("t6_sv_b", a_sv, 0);
    step(1, 0, 1, 0); chk("t6_sv_c", a_sv, 0);
    step(1, 0, 1, 0); chk("t6_sum", a_sum, 4); chk("t6_sv", a_sv, 1);

    // single-sample window, continuous 7s
    do_clear();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 7, 0);
      chk("t7_sv", w_sv, 1); chk("t7_sum", w_sum, 7); chk("t7_acc", w_acc, 0);
    end
    step(0, 0, 0, 0); chk("t7_sv_end", w_sv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
